// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_t              : controller states (IDLE, CMP)
//   RES_EQ/RES_LT/RES_GT : compact result encoding for benches and sub-blocks
//   clog2()              : ceiling log2 for parameter derivation
package cmp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_LT = 2'd1;
    localparam logic [1:0] RES_GT = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational compare of one DIGIT-bit slice, treated as unsigned.
//   a, b : slice operands
//   eq   : a == b
//   gt   : a >  b  (a < b is !eq && !gt)
module cmp_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             eq,
    output logic             gt
);

    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Walks the latched operands MSB-first,
// DIGIT bits per cycle, and finishes at the first differing slice.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; result flags hold the last outcome
//   CMP   | comparing slice idx; busy=1, flags held at 0
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request a compare (accepted only in IDLE)
//   is_signed         : 1 = two's-complement compare, latched with start
//   A, B              : operands, latched with start
//   busy              : compare in progress
//   done              : one-cycle pulse when the result flags become valid
//   A_eq_B/lt/gt      : result flags, exactly one set after done
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_eq_B,
    output logic             A_lt_B,
    output logic             A_gt_B
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int IDXW   = (NSLICE > 1) ? clog2(NSLICE) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("seq_magnitude_comparator: WIDTH must be >= 2");
    end
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
        $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             done_q, done_d;

    // Slice view of the latched operands, slice 0 = most significant.
    logic [DIGIT-1:0] a_slc [NSLICE];
    logic [DIGIT-1:0] b_slc [NSLICE];

    for (genvar i = 0; i < NSLICE; i++) begin : g_slc
        assign a_slc[i] = a_q[WIDTH-1-DIGIT*i -: DIGIT];
        assign b_slc[i] = b_q[WIDTH-1-DIGIT*i -: DIGIT];
    end

    logic [DIGIT-1:0] cur_a;
    logic [DIGIT-1:0] cur_b;
    logic             slc_eq;
    logic             slc_gt;

    assign cur_a = a_slc[idx_q];
    assign cur_b = b_slc[idx_q];

    cmp_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a  (cur_a),
        .b  (cur_b),
        .eq (slc_eq),
        .gt (slc_gt)
    );

    // Signed mode is folded in at latch time: flipping the sign bit of both
    // operands maps two's-complement order onto unsigned order, so the
    // slice walk itself never needs to know the mode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = {A[WIDTH-1] ^ is_signed, A[WIDTH-2:0]};
                    b_d     = {B[WIDTH-1] ^ is_signed, B[WIDTH-2:0]};
                    idx_d   = '0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!slc_eq) begin
                    gt_d    = slc_gt;
                    lt_d    = !slc_gt;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == IDXW'(NSLICE - 1)) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q == CMP);
    assign done   = done_q;
    assign A_eq_B = eq_q;
    assign A_lt_B = lt_q;
    assign A_gt_B = gt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;
    import cmp_pkg::*;

    localparam int WIDTH  = 16;
    localparam int DIGIT  = 2;
    localparam int NSLICE = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             is_signed = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             busy, done, A_eq_B, A_lt_B, A_gt_B;

    int checks = 0;
    int errors = 0;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .A_eq_B    (A_eq_B),
        .A_lt_B    (A_lt_B),
        .A_gt_B    (A_gt_B)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer ordering of the operands as numbers.
    function automatic logic [1:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic s);
        if (s) begin
            if ($signed(a) < $signed(b)) return RES_LT;
            if ($signed(a) > $signed(b)) return RES_GT;
        end else begin
            if (a < b) return RES_LT;
            if (a > b) return RES_GT;
        end
        return RES_EQ;
    endfunction

    // Latency = 1-based position of the first differing DIGIT-bit group from the top.
    function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int x;
        x = int'(a ^ b);
        for (int i = 0; i < NSLICE; i++) begin
            if (((x >> (WIDTH - DIGIT * (i + 1))) & ((1 << DIGIT) - 1)) != 0) return i + 1;
        end
        return NSLICE;
    endfunction

    function automatic logic [2:0] res_flags(input logic [1:0] r);
        case (r)
            RES_EQ:  return 3'b100;
            RES_LT:  return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    // Called at a negedge; raises start for one edge and returns at the next negedge.
    task automatic start_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        A = a;
        B = b;
        is_signed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(input logic [1:0] exp_res, input int exp_lat, input string tag,
                               input int cyc0);
        int cyc;
        bit seen;
        cyc = cyc0;
        seen = 1'b0;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_flags0"}, 32'({A_eq_B, A_lt_B, A_gt_B}), 32'd0);
        while (cyc < 64 && !seen) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else if (cyc < exp_lat) begin
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                chk({tag, "_flagsbusy"}, 32'({A_eq_B, A_lt_B, A_gt_B}), 32'd0);
            end
        end
        chk({tag, "_timeout"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
            chk({tag, "_flags"}, 32'({A_eq_B, A_lt_B, A_gt_B}), 32'(res_flags(exp_res)));
            chk({tag, "_busydone"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                           input string tag, input bit b2b);
        if (!b2b) @(negedge clk);
        start_cmp(a, b, s);
        wait_result(model_res(a, b, s), model_lat(a, b), tag, 0);
    endtask

    task automatic check_hold(input logic [1:0] exp_res, input string tag);
        @(negedge clk);
        chk({tag, "_donelow"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'({A_eq_B, A_lt_B, A_gt_B}), 32'(res_flags(exp_res)));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'({A_eq_B, A_lt_B, A_gt_B}), 32'd0);

        // Directed cases, expected values from the model
        run_cmp(16'h8000, 16'h0000, 1'b0, "u_8000_0", 1'b0);
        chk("u_8000_0_gt", 32'(A_gt_B), 32'd1);
        check_hold(RES_GT, "u_8000_0");
        run_cmp(16'h8000, 16'h0000, 1'b1, "s_8000_0", 1'b0);
        chk("s_8000_0_lt", 32'(A_lt_B), 32'd1);
        run_cmp(16'hFFFF, 16'h0001, 1'b1, "s_ffff_1", 1'b0);
        chk("s_ffff_1_lt", 32'(A_lt_B), 32'd1);
        run_cmp(16'h1234, 16'h1234, 1'b0, "u_eq", 1'b0);
        chk("u_eq_flag", 32'(A_eq_B), 32'd1);
        check_hold(RES_EQ, "u_eq");
        run_cmp(16'h1234, 16'h1234, 1'b1, "s_eq", 1'b0);
        run_cmp(16'h0001, 16'h0002, 1'b0, "u_1_2", 1'b0);
        chk("u_1_2_lt", 32'(A_lt_B), 32'd1);
        run_cmp(16'h0400, 16'h0300, 1'b0, "u_400_300", 1'b0);
        chk("u_400_300_gt", 32'(A_gt_B), 32'd1);

        // start while busy is ignored, and input changes have no effect
        @(negedge clk);
        start_cmp(16'h0001, 16'h0002, 1'b0);
        @(negedge clk);
        A = 16'hFFFF;
        B = 16'h0000;
        is_signed = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result(RES_LT, 8, "ign_start", 2);

        // start in the done cycle is accepted with no dead cycle
        start_cmp(16'h0400, 16'h0300, 1'b0);
        wait_result(RES_GT, 3, "b2b", 0);

        // reset during the third CMP cycle
        @(negedge clk);
        start_cmp(16'h0001, 16'h0002, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_flags", 32'({A_eq_B, A_lt_B, A_gt_B}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midrst_nodone", 32'(done), 32'd0);
        end
        run_cmp(16'h0000, 16'h0000, 1'b0, "post_rst_eq", 1'b0);
        chk("post_rst_lat_eq", 32'(A_eq_B), 32'd1);

        // Randomized compares, some back-to-back
        for (int n = 0; n < 80; n++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = WIDTH'($urandom);
                1:       rb = ra;
                2:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: rb = ra ^ WIDTH'($urandom_range(0, 15));
            endcase
            rs = 1'($urandom_range(0, 1));
            run_cmp(ra, rb, rs, "rand", bit'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
